bkm_csd_monitor: RTL

BKM_CSD_MONITOR -- requirements
Module: bkm_csd_monitor

---
 rtl/bkm_csd_monitor.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bkm_csd_monitor.sv
// Multi-channel CSD-to-binary converter with a fixed-latency pipeline, per-channel
// compare against expected values, saturating error/sample counters and optional freeze-on-error.
module bkm_csd_monitor #(
   parameter int W           = 64,
   parameter int N_CH        = 2,
   parameter int LAT         = 2,
   parameter int CNT_W       = 16,
   parameter int STOP_ON_ERR = 0
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  srst,
   input  logic                  enable,
   input  logic                  in_valid,
   input  logic [N_CH*2*W-1:0]   csd_in,
   input  logic [N_CH*W-1:0]     exp_in,
   input  logic [N_CH-1:0]       chk_en,
   output logic [N_CH*W-1:0]     res,
   output logic                  res_valid,
   output logic [N_CH-1:0]       mismatch,
   output logic [N_CH-1:0]       illegal,
   output logic [CNT_W-1:0]      err_cnt,
   output logic [CNT_W-1:0]      smp_cnt,
   output logic                  frozen
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FROZEN = 2'd2
   } state_t;

   state_t                 state_r, state_nx_s;
   logic [N_CH*W-1:0]      conv_s;
   logic [N_CH-1:0]        mis_in_s, ill_in_s;
   logic                   accept_s, mature_s, err_s;
   logic [N_CH*W-1:0]      res_pipe_r [LAT];
   logic [N_CH-1:0]        mis_pipe_r [LAT];
   logic [N_CH-1:0]        ill_pipe_r [LAT];
   logic [LAT-1:0]         vld_pipe_r;
   logic [N_CH*W-1:0]      res_r;
   logic                   res_valid_r;
   logic [N_CH-1:0]        mismatch_r, illegal_r;
   logic [CNT_W-1:0]       err_cnt_r, smp_cnt_r;
   logic                   frozen_r;

   // A pos/neg pair of 1/1 cancels naturally in (P - N), so no masking is needed.
   function automatic logic [W-1:0] csd_to_bin(input logic [2*W-1:0] csd);
      logic [W-1:0] p, n;
      for (int i = 0; i < W; i++) begin
         p[i] = csd[2*i];
         n[i] = csd[2*i+1];
      end
      return p - n;
   endfunction

   function automatic logic csd_illegal(input logic [2*W-1:0] csd);
      logic ill;
      ill = 1'b0;
      for (int i = 0; i < W; i++) begin
         ill = ill | (csd[2*i] & csd[2*i+1]);
      end
      return ill;
   endfunction

   // Per-channel conversion and compare on the incoming sample
   always_comb begin
      conv_s   = '0;
      mis_in_s = '0;
      ill_in_s = '0;
      for (int c = 0; c < N_CH; c++) begin
         conv_s[c*W +: W] = csd_to_bin(csd_in[c*2*W +: 2*W]);
         ill_in_s[c]      = csd_illegal(csd_in[c*2*W +: 2*W]);
         mis_in_s[c]      = chk_en[c] & (conv_s[c*W +: W] != exp_in[c*W +: W]);
      end
   end

   assign accept_s = in_valid & enable & ~srst & (state_r == ACTIVE);
   assign mature_s = vld_pipe_r[LAT-1] & enable & ~srst & (state_r == ACTIVE);
   assign err_s    = (|mis_pipe_r[LAT-1]) | (|ill_pipe_r[LAT-1]);

   // Next-state logic; srst wins over enable, a stall holds the state
   always_comb begin
      state_nx_s = state_r;
      if (srst) begin
         state_nx_s = IDLE;
      end else if (!enable) begin
         state_nx_s = state_r;
      end else begin
         case (state_r)
            IDLE:    state_nx_s = ACTIVE;
            ACTIVE: begin
               if (mature_s && err_s && (STOP_ON_ERR != 0)) begin
                  state_nx_s = FROZEN;
               end else begin
                  state_nx_s = ACTIVE;
               end
            end
            FROZEN:  state_nx_s = FROZEN;
            default: state_nx_s = IDLE;
         endcase
      end
   end

   // State register and registered frozen flag
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r  <= IDLE;
         frozen_r <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         frozen_r <= (state_nx_s == FROZEN);
      end
   end

   // Conversion pipeline; freezing flushes everything still in flight
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         vld_pipe_r <= '0;
         for (int i = 0; i < LAT; i++) begin
            res_pipe_r[i] <= '0;
            mis_pipe_r[i] <= '0;
            ill_pipe_r[i] <= '0;
         end
      end else if (srst) begin
         vld_pipe_r <= '0;
      end else if (enable) begin
         if (state_nx_s == FROZEN) begin
            vld_pipe_r <= '0;
         end else begin
            vld_pipe_r[0] <= accept_s;
            res_pipe_r[0] <= conv_s;
            mis_pipe_r[0] <= mis_in_s;
            ill_pipe_r[0] <= ill_in_s;
            for (int i = 1; i < LAT; i++) begin
               vld_pipe_r[i] <= vld_pipe_r[i-1];
               res_pipe_r[i] <= res_pipe_r[i-1];
               mis_pipe_r[i] <= mis_pipe_r[i-1];
               ill_pipe_r[i] <= ill_pipe_r[i-1];
            end
         end
      end
   end

   // Result registers and saturating counters, updated only by a matured sample
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         res_r       <= '0;
         res_valid_r <= 1'b0;
         mismatch_r  <= '0;
         illegal_r   <= '0;
         err_cnt_r   <= '0;
         smp_cnt_r   <= '0;
      end else if (srst) begin
         res_r       <= '0;
         res_valid_r <= 1'b0;
         mismatch_r  <= '0;
         illegal_r   <= '0;
         err_cnt_r   <= '0;
         smp_cnt_r   <= '0;
      end else begin
         res_valid_r <= mature_s;
         if (mature_s) begin
            res_r      <= res_pipe_r[LAT-1];
            mismatch_r <= mis_pipe_r[LAT-1];
            illegal_r  <= ill_pipe_r[LAT-1];
            if (smp_cnt_r != {CNT_W{1'b1}}) begin
               smp_cnt_r <= smp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (err_s && (err_cnt_r != {CNT_W{1'b1}})) begin
               err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign res       = res_r;
   assign res_valid = res_valid_r;
   assign mismatch  = mismatch_r;
   assign illegal   = illegal_r;
   assign err_cnt   = err_cnt_r;
   assign smp_cnt   = smp_cnt_r;
   assign frozen    = frozen_r;

endmodule
